// File: rtl/dmem_arb_pkg.sv
// Shared types, sizes and the address legality check for the data-memory arbiter.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package dmem_arb_pkg;

   localparam int NUM_REQ_MAX      = 4;
   localparam int DMEM_DEPTH_WORDS = 4096;
   localparam int WORD_W           = 32;

   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic              we;
   } dmem_req_t;

   typedef struct packed {
      logic [WORD_W-1:0] rdata;
      logic              err;
   } dmem_rsp_t;

   // An access is bad when it is not word aligned or when its word index
   // falls past the end of the memory.
   function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first eligible requester after last_grant wins.
// Latency: purely combinational, no state.
// Backpressure: none of its own; eligibility already folds in response backpressure.
//
// Ports:
//   eligible   in   one bit per requester that may be granted this cycle
//   last_grant in   index of the most recent winner (search starts one past it)
//   grant      out  one-hot winner, or zero when nobody is eligible
//   grant_idx  out  binary index of the winner (0 when grant_vld=0)
//   grant_vld  out  1 when some requester won
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [IDX_W-1:0] cand;

   // Walk the ring once, starting one past the last winner; the last winner
   // itself is visited last, which is what gives strict rotation.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
         if (!grant_vld && eligible[cand]) begin
            grant_vld   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between NUM_REQ requesters, one word access per cycle.
// Latency: request accepted in cycle N -> registered response visible in cycle N+1.
// Backpressure: a requester holding an unaccepted response is not granted until it is taken.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   req_valid/ready/addr/wdata/we per-requester request handshake (ready is combinational)
//   rsp_valid/rdata/err/ready     per-requester registered response handshake
//   mem_addr/write_data/read/write drive the data memory during a granted cycle
//   mem_read_data                 asynchronous read data from the memory
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0][WORD_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][WORD_W-1:0]   req_wdata,
   input  logic [NUM_REQ-1:0]               req_we,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [NUM_REQ-1:0][WORD_W-1:0]   rsp_rdata,
   output logic [NUM_REQ-1:0]               rsp_err,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [WORD_W-1:0]                mem_addr,
   output logic [WORD_W-1:0]                mem_write_data,
   output logic                             mem_read,
   output logic                             mem_write,
   input  logic [WORD_W-1:0]                mem_read_data
);

   localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [WORD_W-1:0] DEPTH_L  = WORD_W'(DEPTH_WORDS);
   localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

   dmem_req_t            req [NUM_REQ];
   dmem_req_t            win_req;
   logic                 win_bad;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_vld;
   logic                 fire;

   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   dmem_rsp_t            rsp_q [NUM_REQ];
   dmem_rsp_t            rsp_d [NUM_REQ];
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;

   // A requester may be granted when its response slot is empty or is being
   // drained this very cycle, so retire and reload can share one edge.
   assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .eligible   (eligible),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_vld  (grant_vld)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = '{addr: req_addr[i], wdata: req_wdata[i], we: req_we[i]};
      end
      win_req = req[grant_idx];
      win_bad = addr_bad(win_req.addr, DEPTH_L);
      // Gating with rst keeps a store presented during reset from reaching memory.
      fire    = grant_vld & ~rst;

      req_ready      = fire ? grant : '0;
      mem_addr       = fire ? win_req.addr  : '0;
      mem_write_data = fire ? win_req.wdata : '0;
      mem_write      = fire &  win_req.we & ~win_bad;
      mem_read       = fire & ~win_req.we & ~win_bad;
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_d        = rsp_q;
      last_grant_d = last_grant_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
            rsp_d[i]       = '0;
         end
      end
      // A new grant overrides the retire above for the winner's slot.
      if (fire) begin
         rsp_valid_d[grant_idx]  = 1'b1;
         rsp_d[grant_idx].rdata  = (win_req.we || win_bad) ? '0 : mem_read_data;
         rsp_d[grant_idx].err    = win_bad;
         last_grant_d            = grant_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= '0;
         last_grant_q <= LAST_RST;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_q[i] <= '0;
         end
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         last_grant_q <= last_grant_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_q[i] <= rsp_d[i];
         end
      end
   end

   always_comb begin
      rsp_valid = rsp_valid_q;
      rsp_rdata = '0;
      rsp_err   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_rdata[i] = rsp_q[i].rdata;
         rsp_err[i]   = rsp_q[i].err;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: fixed vector table, hand-built corner sequences and
// random traffic, all checked against a transaction-level model with its own
// shadow memory.
module tb_dmem_arbiter;

   localparam int N     = 2;
   localparam int DEPTH = 4096;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid, req_ready, req_we;
   logic [N-1:0][31:0]   req_addr, req_wdata, rsp_rdata;
   logic [N-1:0]         rsp_valid, rsp_err, rsp_ready;
   logic [31:0]          mem_addr, mem_write_data, mem_read_data;
   logic                 mem_read, mem_write;

   always #5 clk = ~clk;

   dmem_arbiter #(.NUM_REQ(N), .DEPTH_WORDS(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_we         (req_we),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .rsp_ready      (rsp_ready),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   // The data memory itself: asynchronous read, write at the clock edge.
   logic [31:0] tb_mem [0:DEPTH-1];
   assign mem_read_data = tb_mem[mem_addr[13:2]];
   always @(posedge clk) if (mem_write) tb_mem[mem_addr[13:2]] <= mem_write_data;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:DEPTH-1];
   logic [N-1:0] m_rv, m_err;
   logic [31:0]  m_rd [N];
   int           m_last;
   int           m_win;
   logic         m_bad, m_we;
   logic [31:0]  m_a, m_wd;

   function automatic void model_reset();
      m_rv   = '0;
      m_err  = '0;
      for (int i = 0; i < N; i++) m_rd[i] = 32'h0;
      m_last = N - 1;
      m_win  = -1;
   endfunction

   // Settle the inputs, pick the expected winner and check the combinational outputs.
   task automatic comb_check(input string tag);
      logic [N-1:0] xr;
      logic         xmr, xmw;
      logic [31:0]  xa, xd;
      #2;
      m_win = -1;
      if (!rst) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_win < 0 && req_valid[j] && (!m_rv[j] || rsp_ready[j])) m_win = j;
         end
      end
      xr = '0; xmr = 1'b0; xmw = 1'b0; xa = 32'h0; xd = 32'h0; m_bad = 1'b0;
      if (m_win >= 0) begin
         m_a   = req_addr[m_win];
         m_wd  = req_wdata[m_win];
         m_we  = req_we[m_win];
         m_bad = (m_a % 4 != 0) || (m_a / 4 >= DEPTH);
         xr[m_win] = 1'b1;
         xa  = m_a;
         xd  = m_wd;
         xmw = m_we && !m_bad;
         xmr = !m_we && !m_bad;
      end
      chk({tag, " req_ready"}, 32'(req_ready), 32'(xr));
      chk({tag, " mem_read"}, 32'(mem_read), 32'(xmr));
      chk({tag, " mem_write"}, 32'(mem_write), 32'(xmw));
      chk({tag, " mem_addr"}, mem_addr, xa);
      chk({tag, " mem_write_data"}, mem_write_data, xd);
   endtask

   // Advance the model across the clock edge, then check registered responses.
   task automatic edge_check(input string tag);
      for (int i = 0; i < N; i++) begin
         if (m_rv[i] && rsp_ready[i]) begin
            m_rv[i] = 1'b0; m_rd[i] = 32'h0; m_err[i] = 1'b0;
         end
      end
      if (m_win >= 0) begin
         m_rv[m_win]  = 1'b1;
         m_err[m_win] = m_bad;
         m_rd[m_win]  = (m_bad || m_we) ? 32'h0 : ref_mem[m_a / 4];
         if (!m_bad && m_we) ref_mem[m_a / 4] = m_wd;
         m_last = m_win;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s rsp_valid[%0d]", tag, i), 32'(rsp_valid[i]), 32'(m_rv[i]));
         chk($sformatf("%s rsp_rdata[%0d]", tag, i), rsp_rdata[i], m_rd[i]);
         chk($sformatf("%s rsp_err[%0d]", tag, i), 32'(rsp_err[i]), 32'(m_err[i]));
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  vld, we;
      logic [31:0] a0, a1, d0, d1;
      logic [1:0]  x_rdy;
      logic        x_mr, x_mw;
      logic [1:0]  x_rv;
      logic [31:0] x_rd0, x_rd1;
      logic [1:0]  x_err;
   } vec_t;

   function automatic vec_t mkv(input logic [1:0] vld, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] x_rdy, input logic x_mr, input logic x_mw,
                                input logic [1:0] x_rv, input logic [31:0] x_rd0,
                                input logic [31:0] x_rd1, input logic [1:0] x_err);
      vec_t v;
      v.vld = vld; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.x_rdy = x_rdy; v.x_mr = x_mr; v.x_mw = x_mw; v.x_rv = x_rv;
      v.x_rd0 = x_rd0; v.x_rd1 = x_rd1; v.x_err = x_err;
      return v;
   endfunction

   vec_t vt [14];

   // Bound on total simulated time, independent of the stimulus below.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int won;
      int r;

      for (int i = 0; i < DEPTH; i++) begin
         tb_mem[i]  = 32'h0;
         ref_mem[i] = 32'h0;
      end

      // Rows assume: just out of reset (requester 0 first), memory all zero.
      //               vld    we     a0         a1         d0            d1            rdy   mr    mw    rv     rd0           rd1           err
      vt[0]  = mkv(2'b01, 2'b01, 32'h10,    32'h0,     32'hDEADBEEF, 32'h0,        2'b01, 1'b0, 1'b1, 2'b01, 32'h0,        32'h0,        2'b00);
      vt[1]  = mkv(2'b01, 2'b00, 32'h10,    32'h0,     32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0,        2'b00);
      vt[2]  = mkv(2'b00, 2'b00, 32'h0,     32'h0,     32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b00);
      vt[3]  = mkv(2'b11, 2'b00, 32'h14,    32'h10,    32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 2'b10, 32'h0,        32'hDEADBEEF, 2'b00);
      vt[4]  = mkv(2'b11, 2'b00, 32'h14,    32'h10,    32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 2'b01, 32'h0,        32'h0,        2'b00);
      vt[5]  = mkv(2'b11, 2'b00, 32'h14,    32'h10,    32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 2'b10, 32'h0,        32'hDEADBEEF, 2'b00);
      vt[6]  = mkv(2'b01, 2'b00, 32'h13,    32'h0,     32'h0,        32'h0,        2'b01, 1'b0, 1'b0, 2'b01, 32'h0,        32'h0,        2'b01);
      vt[7]  = mkv(2'b10, 2'b10, 32'h0,     32'h4000,  32'h0,        32'h12345678, 2'b10, 1'b0, 1'b0, 2'b10, 32'h0,        32'h0,        2'b10);
      vt[8]  = mkv(2'b01, 2'b00, 32'h0,     32'h0,     32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 2'b01, 32'h0,        32'h0,        2'b00);
      vt[9]  = mkv(2'b10, 2'b10, 32'h0,     32'h3FFC,  32'h0,        32'hA5A5A5A5, 2'b10, 1'b0, 1'b1, 2'b10, 32'h0,        32'h0,        2'b00);
      vt[10] = mkv(2'b10, 2'b00, 32'h0,     32'h3FFC,  32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 2'b10, 32'h0,        32'hA5A5A5A5, 2'b00);
      vt[11] = mkv(2'b01, 2'b01, 32'h3FFE,  32'h0,     32'hFFFFFFFF, 32'h0,        2'b01, 1'b0, 1'b0, 2'b01, 32'h0,        32'h0,        2'b01);
      vt[12] = mkv(2'b10, 2'b00, 32'h0,     32'h3FFC,  32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 2'b10, 32'h0,        32'hA5A5A5A5, 2'b00);
      vt[13] = mkv(2'b00, 2'b00, 32'h0,     32'h0,     32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b00);

      // ---- reset state, with requests already pending ----
      rst       = 1'b1;
      req_valid = 2'b11;
      req_we    = 2'b01;
      req_addr  = '0;
      req_addr[0] = 32'h10;
      req_wdata = '0;
      req_wdata[0] = 32'h11111111;
      rsp_ready = 2'b00;
      #2;
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset rsp_rdata0", rsp_rdata[0], 32'h0);
      chk("reset rsp_rdata1", rsp_rdata[1], 32'h0);
      chk("reset rsp_err", 32'(rsp_err), 32'h0);
      chk("reset req_ready", 32'(req_ready), 32'h0);
      chk("reset mem_read", 32'(mem_read), 32'h0);
      chk("reset mem_write", 32'(mem_write), 32'h0);
      @(posedge clk); #1;
      chk("reset store dropped", tb_mem[4], 32'h0);
      rst = 1'b0;
      req_valid = '0;
      model_reset();

      // ---- table ----
      rsp_ready = 2'b11;
      for (int t = 0; t < 14; t++) begin
         string tag;
         tag = $sformatf("vec%0d", t);
         req_valid    = vt[t].vld;
         req_we       = vt[t].we;
         req_addr[0]  = vt[t].a0;
         req_addr[1]  = vt[t].a1;
         req_wdata[0] = vt[t].d0;
         req_wdata[1] = vt[t].d1;
         comb_check(tag);
         chk({tag, " tbl req_ready"}, 32'(req_ready), 32'(vt[t].x_rdy));
         chk({tag, " tbl mem_read"}, 32'(mem_read), 32'(vt[t].x_mr));
         chk({tag, " tbl mem_write"}, 32'(mem_write), 32'(vt[t].x_mw));
         edge_check(tag);
         chk({tag, " tbl rsp_valid"}, 32'(rsp_valid), 32'(vt[t].x_rv));
         chk({tag, " tbl rsp_rdata0"}, rsp_rdata[0], vt[t].x_rd0);
         chk({tag, " tbl rsp_rdata1"}, rsp_rdata[1], vt[t].x_rd1);
         chk({tag, " tbl rsp_err"}, 32'(rsp_err), 32'(vt[t].x_err));
      end
      chk("bad store left word 0", tb_mem[0], 32'h0);
      chk("bad store left last word", tb_mem[DEPTH-1], 32'hA5A5A5A5);

      // ---- backpressure: response held, no new grant until it is taken ----
      rsp_ready   = 2'b10;
      req_valid   = 2'b01;
      req_we      = 2'b00;
      req_addr[0] = 32'h10;
      comb_check("bp0");
      edge_check("bp0");
      req_addr[0] = 32'h3FFC;
      for (int c = 0; c < 3; c++) begin
         comb_check($sformatf("bp_hold%0d", c));
         chk("bp_hold req_ready", 32'(req_ready), 32'h0);
         edge_check($sformatf("bp_hold%0d", c));
         chk("bp_hold rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      end
      rsp_ready = 2'b11;
      comb_check("bp_release");
      chk("bp_release req_ready", 32'(req_ready), 32'h1);
      edge_check("bp_release");
      req_valid = '0;
      comb_check("bp_idle");
      edge_check("bp_idle");

      // ---- same-word race: store wins first, then the load sees it ----
      do_reset();
      rsp_ready    = 2'b11;
      req_valid    = 2'b11;
      req_we       = 2'b01;
      req_addr[0]  = 32'h20;
      req_addr[1]  = 32'h20;
      req_wdata[0] = 32'h1;
      comb_check("race1");
      chk("race1 req_ready", 32'(req_ready), 32'h1);
      edge_check("race1");
      req_valid[0] = 1'b0;
      comb_check("race2");
      edge_check("race2");
      chk("race load data", rsp_rdata[1], 32'h1);
      req_valid = '0;

      // ---- asynchronous reset in the middle of traffic ----
      rsp_ready   = 2'b00;
      req_valid   = 2'b10;
      req_we      = 2'b00;
      req_addr[1] = 32'h20;
      comb_check("arst_setup");
      edge_check("arst_setup");
      req_valid    = 2'b01;
      req_we       = 2'b01;
      req_addr[0]  = 32'h24;
      req_wdata[0] = 32'hBAD0BAD0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("arst rsp_rdata1", rsp_rdata[1], 32'h0);
      chk("arst req_ready", 32'(req_ready), 32'h0);
      chk("arst mem_write", 32'(mem_write), 32'h0);
      chk("arst mem_read", 32'(mem_read), 32'h0);
      @(posedge clk); #1;
      chk("arst store dropped", tb_mem[9], 32'h0);
      rst = 1'b0;
      model_reset();
      rsp_ready   = 2'b11;
      req_valid   = 2'b11;
      req_we      = 2'b00;
      req_addr[0] = 32'h24;
      req_addr[1] = 32'h20;
      comb_check("arst_after");
      chk("arst_after req_ready", 32'(req_ready), 32'h1);
      edge_check("arst_after");
      req_valid = '0;

      // ---- random traffic ----
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 9) < 6) begin
               req_valid[i] = 1'b1;
               req_we[i]    = 1'($urandom_range(0, 1));
               req_wdata[i] = $urandom;
               r = $urandom_range(0, 9);
               if (r == 0)      req_addr[i] = 32'(($urandom_range(0, 7) << 2) | $urandom_range(1, 3));
               else if (r == 1) req_addr[i] = 32'(DEPTH * 4 + ($urandom_range(0, 15) << 2));
               else if (r == 2) req_addr[i] = 32'h3FFC;
               else             req_addr[i] = 32'($urandom_range(0, 7) << 2);
            end
            rsp_ready[i] = ($urandom_range(0, 3) != 0);
         end
         comb_check($sformatf("rnd%0d", c));
         won = m_win;
         edge_check($sformatf("rnd%0d", c));
         if (won >= 0) req_valid[won] = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
